sram_arbiter: RTL

//  Shares the single external 8-bit SRAM between three requesters: video fetch, Z80 CPU
//  (memory cycles decoded from cpu_bus memreq/rd/wr) and an aux DMA port (loader/SD).

---
 rtl/sram_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one external 8-bit SRAM between the video fetch, CPU
//               and aux DMA ports. Video has strict priority and CPU/aux
//               alternate round-robin. Every access is fixed-length and ends
//               with a one-cycle ack on the granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_wr,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic              aux_ack,
    output logic [7:0]        aux_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    localparam logic [1:0] c_GNT_VID = 2'd0;
    localparam logic [1:0] c_GNT_CPU = 2'd1;
    localparam logic [1:0] c_GNT_AUX = 2'd2;

    localparam logic [3:0] c_CNT_LAST = 4'(ACCESS_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [1:0]        r_gnt;
    logic              r_wr;
    logic              r_rr_last_aux;
    logic              w_any_req;
    logic              w_last;
    logic [1:0]        w_sel;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_wdata;

    // Pin and port registers; the SRAM pins come straight from flops.
    logic              r_vid_ack, r_cpu_ack, r_aux_ack;
    logic [7:0]        r_vid_rdata, r_cpu_rdata, r_aux_rdata;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [7:0]        r_dq_o;
    logic              r_dq_oe, r_we_n, r_oe_n;

    assign vid_ack    = r_vid_ack;
    assign cpu_ack    = r_cpu_ack;
    assign aux_ack    = r_aux_ack;
    assign vid_rdata  = r_vid_rdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign aux_rdata  = r_aux_rdata;
    assign sram_addr  = r_sram_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_we_n  = r_we_n;
    assign sram_oe_n  = r_oe_n;
    assign busy       = (r_state != c_S_IDLE);

    // Grant selection: video first, otherwise CPU/aux take turns on a tie.
    always_comb begin
        w_any_req   = vid_req | cpu_req | aux_req;
        w_last      = (r_cnt == c_CNT_LAST);
        w_sel       = c_GNT_AUX;
        if (vid_req)
            w_sel = c_GNT_VID;
        else if (cpu_req && aux_req)
            w_sel = r_rr_last_aux ? c_GNT_CPU : c_GNT_AUX;
        else if (cpu_req)
            w_sel = c_GNT_CPU;
        w_sel_wr    = 1'b0;
        w_sel_addr  = aux_addr;
        w_sel_wdata = aux_wdata;
        case (w_sel)
            c_GNT_VID: begin
                w_sel_addr  = vid_addr;
                w_sel_wdata = 8'h00;
            end
            c_GNT_CPU: begin
                w_sel_wr    = cpu_wr;
                w_sel_addr  = cpu_addr;
                w_sel_wdata = cpu_wdata;
            end
            default: w_sel_wr = aux_wr;
        endcase
    end

    // State register.
    always_ff @(posedge clk28) begin
        if (!rst_n)
            r_state <= c_S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: IDLE -> ACCESS (ACCESS_CYCLES clocks) -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (w_any_req) w_state_nxt = c_S_ACCESS;
            c_S_ACCESS: if (w_last)    w_state_nxt = c_S_DONE;
            c_S_DONE:   w_state_nxt = c_S_IDLE;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    // Access datapath: latch the grant, drive strobes, capture read data, ack.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            r_cnt         <= 4'd0;
            r_gnt         <= c_GNT_VID;
            r_wr          <= 1'b0;
            r_rr_last_aux <= 1'b1;
            r_vid_ack     <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_aux_ack     <= 1'b0;
            r_vid_rdata   <= 8'h00;
            r_cpu_rdata   <= 8'h00;
            r_aux_rdata   <= 8'h00;
            r_sram_addr   <= '0;
            r_dq_o        <= 8'h00;
            r_dq_oe       <= 1'b0;
            r_we_n        <= 1'b1;
            r_oe_n        <= 1'b1;
        end else begin
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_aux_ack <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt       <= w_sel;
                        r_wr        <= w_sel_wr;
                        r_cnt       <= 4'd0;
                        r_sram_addr <= w_sel_addr;
                        r_dq_o      <= w_sel_wdata;
                        r_dq_oe     <= w_sel_wr;
                        // First ACCESS cycle is never the last one, so a write strobes here.
                        r_we_n      <= ~w_sel_wr;
                        r_oe_n      <= w_sel_wr;
                    end
                end
                c_S_ACCESS: begin
                    if (!w_last) begin
                        r_cnt  <= r_cnt + 4'd1;
                        // Drop we_n one cycle early so data/address hold past the strobe.
                        r_we_n <= ~(r_wr && ((r_cnt + 4'd1) != c_CNT_LAST));
                    end else begin
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        case (r_gnt)
                            c_GNT_VID: begin
                                r_vid_ack   <= 1'b1;
                                r_vid_rdata <= sram_dq_i;
                            end
                            c_GNT_CPU: begin
                                r_cpu_ack     <= 1'b1;
                                r_rr_last_aux <= 1'b0;
                                if (!r_wr) r_cpu_rdata <= sram_dq_i;
                            end
                            default: begin
                                r_aux_ack     <= 1'b1;
                                r_rr_last_aux <= 1'b1;
                                if (!r_wr) r_aux_rdata <= sram_dq_i;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
